// File: rtl/gate_check_pkg.sv
// Shared types and constants for the 2-input gate checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;

  localparam logic [NUM_VECTORS-1:0] NAND_TT = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] AND_TT  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] OR_TT   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/gate_checker_if.sv
// Control, stimulus and result signals between a gate checker and its environment.
interface gate_checker_if;
  import gate_check_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] expected;
  logic                   y_in;
  logic                   a_out;
  logic                   b_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [2:0]             err_count;
  logic [NUM_VECTORS-1:0] fail_vec;

  modport master (
    output start, expected, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, expected, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/settle_timer.sv
// Down-counter that expires on the last cycle of a SETTLE-cycle hold window.
module settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] SETTLE,
  output logic       expire
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = SETTLE - 4'd1;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign expire = (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_checker.sv
// Exhaustively drives the four input vectors of a 2-input gate and compares its
// output against a latched truth table.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input logic           clk,
  input logic           reset,
  gate_checker_if.slave gc
);

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [NUM_VECTORS-1:0] exp_q, exp_d;
  logic [NUM_VECTORS-1:0] fail_q, fail_d;
  logic [2:0]             err_q, err_d;
  logic                   pass_q, pass_d;
  logic                   load;
  logic                   expire;
  logic                   accept;
  logic                   mismatch;

  settle_timer u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .SETTLE (4'(SETTLE)),
    .expire (expire)
  );

  assign accept = gc.start && (state_q != StRun);
  // Case inequality so an X/Z from the gate counts as a mismatch in simulation.
  assign mismatch = (gc.y_in !== exp_q[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    fail_d  = fail_q;
    err_d   = err_q;
    pass_d  = pass_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StRun;
          idx_d   = 2'd0;
          exp_d   = gc.expected;
          fail_d  = '0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (expire) begin
          if (mismatch) begin
            fail_d[idx_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          if (idx_q == 2'd3) begin
            state_d = StDone;
            pass_d  = (err_d == 3'd0);
          end else begin
            idx_d = idx_q + 2'd1;
            load  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      exp_q   <= '0;
      fail_q  <= '0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign gc.busy      = (state_q == StRun);
  assign gc.done      = (state_q == StDone);
  assign gc.a_out     = gc.busy & idx_q[0];
  assign gc.b_out     = gc.busy & idx_q[1];
  assign gc.pass      = pass_q;
  assign gc.err_count = err_q;
  assign gc.fail_vec  = fail_q;

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles each input vector is held before its output is sampled (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a check run; accepted only when busy is 0.
REQ-005 SHALL have port expected  input  4  truth table of the gate under test; bit idx is the expected output for vector idx.
REQ-006 SHALL have port y_in  input  1  output of the 2-input gate under test.
REQ-007 SHALL have port a_out  output  1  first gate input driven to the gate under test.
REQ-008 SHALL have port b_out  output  1  second gate input driven to the gate under test.
REQ-009 SHALL have port busy  output  1  run in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking end of run.
REQ-011 SHALL have port pass  output  1  last run had zero mismatches.
REQ-012 SHALL have port err_count  output  3  mismatch count of last run (0..4).
REQ-013 SHALL have port fail_vec  output  4  bit idx set if vector idx mismatched.

Function
REQ-014 SHALL apply vectors in order idx 0..3 with a_out=idx[0] and b_out=idx[1], i.e. (a,b) = 00, 10, 01, 11.
REQ-015 SHALL use states IDLE, RUN and DONE, with IDLE->RUN on an accepted start, RUN->DONE after vector 3 is sampled, DONE->IDLE unconditionally, and DONE->RUN on an accepted start.
REQ-016 SHALL latch expected, and clear err_count, fail_vec and pass, on the edge at which start is accepted.
REQ-017 SHALL hold each vector on a_out/b_out for exactly SETTLE cycles, sampling y_in at the last of those cycles.
REQ-018 SHALL count a mismatch when the sampled y_in differs from the latched expected[idx], setting fail_vec[idx] and incrementing err_count.
REQ-019 SHALL, in simulation, treat y_in of X or Z as a mismatch.
REQ-020 SHALL give this timing when start is accepted at the end of cycle 0: busy=1 in cycles 1..4*SETTLE; done=1 and busy=0 in cycle 4*SETTLE+1 only.
REQ-021 SHALL drive pass=1 in the done cycle if and only if err_count==0, and hold pass, err_count and fail_vec until the next accepted start.
REQ-022 SHALL ignore start while busy=1, with no restart and no effect on results.
REQ-023 SHALL accept start asserted in the DONE cycle, beginning a new run in the next cycle.
REQ-024 SHALL drive a_out=b_out=0 whenever not in RUN.

Reset
REQ-025 SHALL, on reset, enter IDLE with a_out, b_out, busy, done, pass, err_count and fail_vec all 0, and clear the settle counter and idx.
REQ-026 SHALL, on reset asserted mid-run, abort the run with no done pulse, and take priority over a simultaneous start.

Structure
REQ-027 SHALL place the following in package gate_check_pkg: the state enum, NUM_VECTORS=4, and truth-table constants NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110 and XOR_TT=4'b0110.
REQ-028 SHALL implement the per-vector hold timing in one sub-module, settle_timer, with inputs load and SETTLE and output expire.

Verification
REQ-029 SHALL cover: correct NAND DUT, expected=NAND_TT, SETTLE=2, start at cycle 0 -> done at cycle 9, pass=1, err_count=0, fail_vec=0000.
REQ-030 SHALL cover: y_in tied to 1, expected=NAND_TT -> pass=0, err_count=1, fail_vec=1000.
REQ-031 SHALL cover: NAND DUT checked against AND_TT -> pass=0, err_count=4, fail_vec=1111.
REQ-032 SHALL cover: start pulsed again at cycle 4 -> done still at cycle 9 only, results unchanged.
REQ-033 SHALL cover: reset asserted at cycle 5 -> next cycle all outputs 0, no done; fresh start then completes normally.
REQ-034 SHALL cover: SETTLE=1 with a correct NAND DUT -> a_out/b_out step every cycle 1..4, done at cycle 5, pass=1.
